blinky_led: RTL and testbench

- Free-running LED pattern generator for a 6-LED board driven from a 50 MHz clock.
- A prescaler produces a slow step tick. A small sequencer alternates between two patterns:
  - a 6-bit binary up-count;
  - a one-hot bounce scan.
- Outputs are registered and polarity-configurable; default is active-low board LEDs.
- Top-level leaf block with no upstream handshake.

---
 rtl/blinky_led.sv | 93 +++++++++
 tb/tb_blinky_led.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/blinky_led.sv
`timescale 1ns/1ps
// Free-running 6-LED pattern generator: 64-step binary count, then a 10-step one-hot bounce.
// led is registered and changes on the prescaler tick edge; no flow control, never stalls.
module blinky_led #(
  parameter int DIV_CYCLES     = 12_500_000,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] led
);

  localparam int            PW        = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(DIV_CYCLES - 1);
  localparam logic [5:0]    LED_RESET = LED_ACTIVE_LOW ? 6'b111111 : 6'b000000;

  typedef enum logic {
    COUNT = 1'b0,
    SCAN  = 1'b1
  } mode_t;

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [PW-1:0] prescaler;
  logic          tick;
  mode_t         mode, mode_nxt;
  logic [5:0]    step, step_nxt;
  logic [2:0]    scan_pos;
  logic [5:0]    pattern_nxt;
  logic [5:0]    led_nxt;

  // Reset asserts immediately but releases only after two clean clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  assign tick = (prescaler == PS_LAST);

  always_comb begin
    mode_nxt = mode;
    step_nxt = step;
    if (mode == COUNT) begin
      if (step == 6'd63) begin
        mode_nxt = SCAN;
        step_nxt = 6'd0;
      end else begin
        step_nxt = step + 6'd1;
      end
    end else begin
      if (step == 6'd9) begin
        mode_nxt = COUNT;
        step_nxt = 6'd0;
      end else begin
        step_nxt = step + 6'd1;
      end
    end
  end

  // Scan index 0..9 folds back into lit positions 0..5..1.
  assign scan_pos    = (step_nxt <= 6'd5) ? step_nxt[2:0] : 3'(6'd10 - step_nxt);
  assign pattern_nxt = (mode_nxt == COUNT) ? step_nxt : (6'b000001 << scan_pos);
  assign led_nxt     = LED_ACTIVE_LOW ? ~pattern_nxt : pattern_nxt;

  // Pins are loaded from the next pattern so they move on the same edge as the sequencer.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mode <= COUNT;
      step <= 6'd0;
      led  <= LED_RESET;
    end else if (tick) begin
      mode <= mode_nxt;
      step <= step_nxt;
      led  <= led_nxt;
    end
  end

endmodule

// File: tb/tb_blinky_led.sv
`timescale 1ns/1ps
// Scoreboarded bench for blinky_led: active-low and active-high instances share clk and reset.
module tb_blinky_led;

  localparam int DIV = 4;

  typedef struct {
    int         cyc;
    logic [5:0] la;
    logic [5:0] lb;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] led_a;
  logic [5:0] led_b;
  int         cyc   = 0;
  int         ncmp  = 0;
  int         nerr  = 0;
  int         rel   = 0;
  exp_t       q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blinky_led #(.DIV_CYCLES(DIV), .LED_ACTIVE_LOW(1'b1)) u_lo (
    .clk  (clk),
    .rst_n(rst_n),
    .led  (led_a)
  );

  blinky_led #(.DIV_CYCLES(DIV), .LED_ACTIVE_LOW(1'b0)) u_hi (
    .clk  (clk),
    .rst_n(rst_n),
    .led  (led_b)
  );

  // Logical pattern shown after n ticks since reset release.
  function automatic logic [5:0] exp_pat(input int n);
    int         k;
    int         p;
    logic [5:0] one;
    one = 6'd1;
    k   = n % 74;
    if (k < 64) return 6'(k);
    p = (k - 64 <= 5) ? (k - 64) : (74 - k);
    return one << p;
  endfunction

  task automatic release_and_push(input int nt);
    exp_t e;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rel   = cyc;
    for (int n = 1; n <= nt; n++) begin
      e.cyc = rel + 2 + DIV * n;
      e.lb  = exp_pat(n);
      e.la  = ~e.lb;
      q.push_back(e);
    end
  endtask

  task automatic check_led(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    ncmp++;
    assert (led_a === ea) else begin
      nerr++;
      $error("FAIL %s led_a observed=%b expected=%b", tag, led_a, ea);
    end
    ncmp++;
    assert (led_b === eb) else begin
      nerr++;
      $error("FAIL %s led_b observed=%b expected=%b", tag, led_b, eb);
    end
  endtask

  task automatic check_drained(input string tag);
    ncmp++;
    assert (q.size() === 0) else begin
      nerr++;
      $error("FAIL %s pending_changes observed=%0d expected=0", tag, q.size());
    end
  endtask

  initial begin
    fork
      begin : monitor
        logic [5:0] pa;
        logic [5:0] pb;
        exp_t       e;
        pa = led_a;
        pb = led_b;
        forever begin
          @(negedge clk);
          if (rst_n && (led_a !== pa || led_b !== pb)) begin
            ncmp++;
            assert (q.size() != 0) else begin
              nerr++;
              $error("FAIL unexpected_change cyc=%0d observed=%b/%b expected=no change", cyc, led_a, led_b);
            end
            if (q.size() != 0) begin
              e = q.pop_front();
              ncmp++;
              assert (cyc === e.cyc) else begin
                nerr++;
                $error("FAIL change_cycle observed=%0d expected=%0d", cyc, e.cyc);
              end
              ncmp++;
              assert (led_a === e.la) else begin
                nerr++;
                $error("FAIL led_a_step cyc=%0d observed=%b expected=%b", cyc, led_a, e.la);
              end
              ncmp++;
              assert (led_b === e.lb) else begin
                nerr++;
                $error("FAIL led_b_step cyc=%0d observed=%b expected=%b", cyc, led_b, e.lb);
              end
            end
          end
          pa = led_a;
          pb = led_b;
        end
      end
    join_none

    // Held in reset: both polarities show all LEDs off.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_led("reset_hold", 6'b111111, 6'b000000);
    end

    // Two full 74-tick periods, then stop partway through the third sweep (SCAN position 3).
    release_and_push(215);
    repeat (864) @(posedge clk);
    #2;
    check_led("pre_reset_scan", ~exp_pat(215), exp_pat(215));
    check_drained("sweep_complete");

    // Asynchronous assertion mid-cycle: pins must return before the next edge.
    rst_n = 1'b0;
    #1;
    check_led("async_reset", 6'b111111, 6'b000000);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_led("reset_hold_again", 6'b111111, 6'b000000);

    // Restart must begin again at COUNT value 1 after a full prescaler wait.
    release_and_push(3);
    repeat (17) @(posedge clk);
    #1;
    check_drained("restart");
    check_led("restart_value", ~exp_pat(3), exp_pat(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
